// File: rtl/muldiv_seq.sv
// muldiv_seq: MULT/MULTU sequencer for the shared 32x32 multiplier and HI/LO owner.
// Define MULDIV_SIGNED_EN to enable signed (MULT) sign-magnitude handling.
module muldiv_seq #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIX} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, done_q, done_d, sgn;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod;
`ifdef MULDIV_SIGNED_EN
  assign sgn  = op_signed;
  assign prod = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
`else
  logic unused_sgn;
  assign unused_sgn = op_signed;
  assign sgn  = 1'b0;
  assign prod = {mul_hi, mul_lo};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = sgn & (rs_val[31] ^ rt_val[31]);
          // |0x80000000| wraps to itself, which is correct read as unsigned
          a_d     = (sgn & rs_val[31]) ? -rs_val : rs_val;
          b_d     = (sgn & rt_val[31]) ? -rt_val : rt_val;
          state_d = LOAD;
        end else begin
          hi_d = mthi ? wdata : hi_q;
          lo_d = mtlo ? wdata : lo_q;
        end
      end
      LOAD: begin
        cnt_d   = 4'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? FIX : WAIT;
      end
      default: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy  = state_q != IDLE;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mul_a = a_q;
  assign mul_b = b_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench driving a LAT=1 and a LAT=4 instance of muldiv_seq.
module tb_muldiv_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  rst, start, sgn, mthi, mtlo, busy, done;
  logic [31:0] rs[2], rt[2], wd[2], hi[2], lo[2], ma[2], mb[2], mh[2], ml[2];
  logic [63:0] q0[$], q1[$];
  int checks = 0, failures = 0;
  genvar g;
  for (g = 0; g < 2; g++) begin : d
    muldiv_seq #(.LAT(g == 0 ? 1 : 4)) u (
      .clk(clk), .reset(rst[g]), .start(start[g]), .op_signed(sgn[g]),
      .rs_val(rs[g]), .rt_val(rt[g]), .mthi(mthi[g]), .mtlo(mtlo[g]), .wdata(wd[g]),
      .busy(busy[g]), .done(done[g]), .hi(hi[g]), .lo(lo[g]),
      .mul_a(ma[g]), .mul_b(mb[g]), .mul_hi(mh[g]), .mul_lo(ml[g]));
    assign {mh[g], ml[g]} = {32'b0, ma[g]} * {32'b0, mb[g]};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic en;
`ifdef MULDIV_SIGNED_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    if (s & en) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    return {32'b0, a} * {32'b0, b};
  endfunction
  always @(negedge clk)
    if (done[0]) begin
      if (q0.size() == 0) check("spurious_done0", 1, 0);
      else check("hilo0", {hi[0], lo[0]}, q0.pop_front());
    end
  always @(negedge clk)
    if (done[1]) begin
      if (q1.size() == 0) check("spurious_done1", 1, 0);
      else check("hilo1", {hi[1], lo[1]}, q1.pop_front());
    end
  task automatic issue(input int k, input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    start[k] = 1'b1;
    sgn[k]   = s;
    rs[k]    = a;
    rt[k]    = b;
    if (push) begin
      if (k == 0) q0.push_back(model(s, a, b));
      else q1.push_back(model(s, a, b));
    end
    @(negedge clk);
    start[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k, input int lat, input bit pulse);
    int n = 0;
    logic [31:0] h0 = hi[k];
    while (busy[k] && n < 40) begin
      if (pulse && n == 1) begin
        start[k] = 1'b1;
        rs[k]    = 32'h1111;
        rt[k]    = 32'h2222;
        mthi[k]  = 1'b1;
        wd[k]    = 32'h1234;
      end
      if (pulse && n == 2) begin
        start[k] = 1'b0;
        mthi[k]  = 1'b0;
        check("hi_locked", hi[k], h0);
      end
      n++;
      @(negedge clk);
    end
    check("busy_len", n, 2 + lat);
    check("done_at_idle", done[k], 1);
  endtask
  task automatic op(input int k, input int lat, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(k, s, a, b, 1);
    wait_idle(k, lat, 0);
  endtask
  task automatic suite(input int k, input int lat);
    op(k, lat, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op(k, lat, 1, 32'hFFFFFFFF, 32'h00000001);
    op(k, lat, 1, 32'h80000000, 32'h80000000);
    op(k, lat, 1, 32'h80000000, 32'h7FFFFFFF);
    op(k, lat, 1, 32'h00000000, 32'h80000000);
    for (int i = 0; i < 6; i++) op(k, lat, 1'($urandom), $urandom, $urandom);
    @(negedge clk);
    issue(k, 1, 32'hFFFFFFF9, 32'h3, 1);
    wait_idle(k, lat, 1);
    @(negedge clk);
    mthi[k] = 1'b1;
    mtlo[k] = 1'b1;
    wd[k]   = 32'hA5A5A5A5;
    @(negedge clk);
    mthi[k] = 1'b0;
    mtlo[k] = 1'b0;
    check("mt_hi", hi[k], 32'hA5A5A5A5);
    check("mt_lo", lo[k], 32'hA5A5A5A5);
    mtlo[k] = 1'b1;
    wd[k]   = 32'hDEADBEEF;
    issue(k, 0, 32'h3, 32'h5, 1);
    mtlo[k] = 1'b0;
    check("mtlo_dropped", lo[k], 32'hA5A5A5A5);
    wait_idle(k, lat, 0);
    @(negedge clk);
    issue(k, 0, 32'h7, 32'h9, 1);
    wait_idle(k, lat, 0);
    issue(k, 1, 32'hFFFFFFFE, 32'h5, 1);
    wait_idle(k, lat, 0);
    @(negedge clk);
    issue(k, 1, 32'h5, 32'h6, 0);
    @(negedge clk);
    @(negedge clk);
    rst[k] = 1'b1;
    #1;
    check("rst_busy", busy[k], 0);
    check("rst_done", done[k], 0);
    check("rst_hilo", {hi[k], lo[k]}, 0);
    check("rst_mul", {ma[k], mb[k]}, 0);
    @(negedge clk);
    rst[k] = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_idle", busy[k], 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 2'b11;
    start = '0;
    sgn = '0;
    mthi = '0;
    mtlo = '0;
    for (int i = 0; i < 2; i++) begin
      rs[i] = '0;
      rt[i] = '0;
      wd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("init_busy", busy[i], 0);
      check("init_done", done[i], 0);
      check("init_hilo", {hi[i], lo[i]}, 0);
      check("init_mul", {ma[i], mb[i]}, 0);
    end
    rst = 2'b00;
    suite(0, 1);
    suite(1, 4);
    check("q_empty0", q0.size(), 0);
    check("q_empty1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
